// File: rtl/float16_pkg.sv
// rtl/float16_pkg.sv - shared binary16 constants, state and operand-class enums
package float16_pkg;

  localparam int          EXP_BIAS  = 15;
  localparam logic [15:0] QNAN      = 16'h7E00;
  localparam logic [15:0] POS_INF   = 16'h7C00;
  localparam int          DIV_STEPS = 13;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } div_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

endpackage

// File: rtl/float16_classify.sv
// rtl/float16_classify.sv - binary16 operand class decode (subnormals count as zero)
import float16_pkg::*;

module float16_classify (
  input  logic [14:0] mag,
  output fp_class_t   cls
);

  always_comb begin
    cls = CLS_NORM;
    if (mag[14:10] == 5'd0) begin
      cls = CLS_ZERO;
    end else if (mag[14:10] == 5'h1f) begin
      cls = (mag[9:0] == 10'd0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/float16_div_seq.sv
// rtl/float16_div_seq.sv - sequential binary16 divider, one quotient bit per cycle
import float16_pkg::*;

module float16_div_seq #(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        clk,
  input  logic        iRst,
  input  logic [15:0] iNum1,
  input  logic [15:0] iNum2,
  input  logic        iValid,
  output logic        oReady,
  output logic [15:0] oNum,
  output logic        oValid,
  input  logic        iReady,
  output logic        oOverflow,
  output logic        oInvalid,
  output logic        oDivZero
);

  div_state_t state, state_nxt;

  logic [15:0]        op_a, op_b;
  logic [11:0]        rem;
  logic [12:0]        quo;
  logic [3:0]         cnt;
  logic               rnd_step;
  logic [9:0]         mant_r;
  logic               g_r, r_r, s_r;
  logic signed [6:0]  exp_r;
  logic [15:0]        res_num;
  logic               res_ovf, res_inv, res_dz;

  fp_class_t          cls_a, cls_b;

  float16_classify u_cls_a (.mag(op_a[14:0]), .cls(cls_a));
  float16_classify u_cls_b (.mag(op_b[14:0]), .cls(cls_b));

  // Shared restoring step: the remainder never exceeds twice the divisor,
  // so a 12-bit difference plus borrow is enough.
  logic [10:0] mb;
  logic [12:0] sub;
  logic        borrow;
  logic [11:0] rem_base;

  assign mb       = {1'b1, op_b[9:0]};
  assign sub      = {1'b0, rem} - {2'b00, mb};
  assign borrow   = sub[12];
  assign rem_base = borrow ? rem : sub[11:0];

  logic              sign;
  logic              inc;
  logic [10:0]       mant_sum;
  logic signed [6:0] exp_f;
  logic [15:0]       pk_num;
  logic              pk_ovf, pk_inv, pk_dz;

  assign sign     = op_a[15] ^ op_b[15];
  assign inc      = ROUND_NEAREST && g_r && (r_r || s_r || mant_r[0]);
  assign mant_sum = {1'b0, mant_r} + {10'd0, inc};
  assign exp_f    = exp_r + {6'd0, mant_sum[10]};

  always_comb begin
    pk_num = {sign, 15'd0};
    pk_ovf = 1'b0;
    pk_inv = 1'b0;
    pk_dz  = 1'b0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
        (cls_a == CLS_INF && cls_b == CLS_INF)) begin
      pk_num = QNAN;
      pk_inv = 1'b1;
    end else if (cls_a == CLS_INF) begin
      pk_num = POS_INF | {sign, 15'd0};
    end else if (cls_b == CLS_ZERO) begin
      pk_num = POS_INF | {sign, 15'd0};
      pk_dz  = 1'b1;
    end else if (cls_b == CLS_INF || cls_a == CLS_ZERO) begin
      pk_num = {sign, 15'd0};
    end else if (exp_f >= 7'sd31) begin
      pk_num = POS_INF | {sign, 15'd0};
      pk_ovf = 1'b1;
    end else if (exp_f <= 7'sd0) begin
      pk_num = {sign, 15'd0};
    end else begin
      pk_num = {sign, exp_f[4:0], mant_sum[9:0]};
    end
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    oReady    = 1'b0;
    oValid    = 1'b0;
    oNum      = 16'd0;
    oOverflow = 1'b0;
    oInvalid  = 1'b0;
    oDivZero  = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) state_nxt = DIV;
      end
      DIV: begin
        if (cnt == 4'(DIV_STEPS - 1)) state_nxt = ROUND;
      end
      ROUND: begin
        if (rnd_step) state_nxt = DONE;
      end
      DONE: begin
        oValid    = 1'b1;
        oNum      = res_num;
        oOverflow = res_ovf;
        oInvalid  = res_inv;
        oDivZero  = res_dz;
        if (iReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      op_a     <= 16'd0;
      op_b     <= 16'd0;
      rem      <= 12'd0;
      quo      <= 13'd0;
      cnt      <= 4'd0;
      rnd_step <= 1'b0;
      mant_r   <= 10'd0;
      g_r      <= 1'b0;
      r_r      <= 1'b0;
      s_r      <= 1'b0;
      exp_r    <= 7'sd0;
      res_num  <= 16'd0;
      res_ovf  <= 1'b0;
      res_inv  <= 1'b0;
      res_dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            op_a     <= iNum1;
            op_b     <= iNum2;
            rem      <= {2'b01, iNum1[9:0]};
            quo      <= 13'd0;
            cnt      <= 4'd0;
            rnd_step <= 1'b0;
          end
        end
        DIV: begin
          quo <= {quo[11:0], ~borrow};
          rem <= rem_base << 1;
          cnt <= cnt + 4'd1;
        end
        ROUND: begin
          // First ROUND cycle normalises; second rounds and packs the result.
          if (!rnd_step) begin
            rnd_step <= 1'b1;
            s_r      <= (rem != 12'd0);
            if (quo[12]) begin
              mant_r <= quo[11:2];
              g_r    <= quo[1];
              r_r    <= quo[0];
            end else begin
              mant_r <= quo[10:1];
              g_r    <= quo[0];
              r_r    <= 1'b0;
            end
            exp_r <= {2'b00, op_a[14:10]} - {2'b00, op_b[14:10]} + 7'(EXP_BIAS)
                     - {6'd0, ~quo[12]};
          end else begin
            res_num <= pk_num;
            res_ovf <= pk_ovf;
            res_inv <= pk_inv;
            res_dz  <= pk_dz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
